// File: rtl/ndata_to_axi_packer_if.sv
// Handshake bundles for ndata_to_axi_packer: element-type channel, ndata lane stream and the
// packed AXI4-Stream output.

interface ndata_type_if;
  // data carries the element width in bits directly (GET_TYPE_WIDTH is the identity map)
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface ndata_if #(
  parameter int unsigned NUM_ELEMENTS    = 8,
  parameter int unsigned CONTAINER_WIDTH = 64
);
  logic                                       valid;
  logic                                       ready;
  logic                                       last;
  logic [NUM_ELEMENTS-1:0][CONTAINER_WIDTH-1:0] data;
  logic [NUM_ELEMENTS-1:0]                    keep;

  modport master (output valid, output last, output data, output keep, input ready);
  modport slave  (input valid, input last, input data, input keep, output ready);
endinterface

interface axi4s_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;

  modport master (output tvalid, output tlast, output tdata, output tkeep, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tkeep, output tready);
endinterface

// File: rtl/ndata_to_axi_packer.sv
// Packs narrow elements from NUM_ELEMENTS lanes into full AXI4-Stream beats.
// Optional NDATA_PACK_BEAT_COUNT_EN adds beat_count and xfer_done outputs.

module ndata_to_axi_packer #(
  parameter int unsigned NUM_ELEMENTS    = 8,
  parameter int unsigned CONTAINER_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  ndata_type_if.slave  actual_type,
  ndata_if.slave       in,
  axi4s_if.master      out,
  output logic         err
`ifdef NDATA_PACK_BEAT_COUNT_EN
  ,
  output logic [31:0]  beat_count,
  output logic         xfer_done
`endif
);

  localparam int unsigned AXI_WIDTH  = CONTAINER_WIDTH * NUM_ELEMENTS;
  localparam int unsigned KEEP_WIDTH = AXI_WIDTH / 8;
  localparam int unsigned MAX_SLOTS  = CONTAINER_WIDTH / 8;
  localparam int unsigned SLOT_W     = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam int unsigned KEEP_IDX_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

  function automatic logic [7:0] get_type_width(logic [7:0] t);
    return t;
  endfunction

  logic [SLOT_W-1:0]                slot_q, slot_d;
  logic [KEEP_WIDTH-1:0][7:0]       asm_data_q, asm_data_d;
  logic [KEEP_WIDTH-1:0]            asm_keep_q, asm_keep_d;
  logic [KEEP_WIDTH-1:0][7:0]       out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0]            out_keep_q, out_keep_d;
  logic                             out_last_q, out_last_d;
  logic                             out_valid_q, out_valid_d;
  logic                             err_q, err_d;

  logic [7:0]                       w;
  int unsigned                      elem_bytes;
  logic [SLOT_W-1:0]                last_slot;
  logic                             unsupported;
  logic                             in_ready;
  logic                             beat_acc;
  logic                             close;
  logic [KEEP_IDX_W-1:0]            byte_idx;
  logic [KEEP_WIDTH-1:0][7:0]       merged_data;
  logic [KEEP_WIDTH-1:0]            merged_keep;

  // Unsupported widths fall back to one element per container (single slot).
  always_comb begin
    w           = get_type_width(actual_type.data);
    elem_bytes  = CONTAINER_WIDTH / 8;
    last_slot   = '0;
    unsupported = 1'b1;
    if (32'(w) <= CONTAINER_WIDTH) begin
      unique case (w)
        8'd8: begin
          elem_bytes  = 1;
          last_slot   = SLOT_W'(CONTAINER_WIDTH / 8 - 1);
          unsupported = 1'b0;
        end
        8'd16: begin
          elem_bytes  = 2;
          last_slot   = SLOT_W'(CONTAINER_WIDTH / 16 - 1);
          unsupported = 1'b0;
        end
        8'd32: begin
          elem_bytes  = 4;
          last_slot   = SLOT_W'(CONTAINER_WIDTH / 32 - 1);
          unsupported = 1'b0;
        end
        8'd64: begin
          elem_bytes  = 8;
          last_slot   = SLOT_W'(CONTAINER_WIDTH / 64 - 1);
          unsupported = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = rst_n && actual_type.valid && (!out_valid_q || out.tready);
  assign beat_acc = in.valid && in_ready;
  assign close    = beat_acc && ((slot_q == last_slot) || in.last);

  // Element i of slot s lands at element position s*NUM_ELEMENTS+i of the output word.
  always_comb begin
    merged_data = asm_data_q;
    merged_keep = asm_keep_q;
    byte_idx    = '0;
    if (beat_acc) begin
      for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
        for (int unsigned b = 0; b < CONTAINER_WIDTH / 8; b++) begin
          if (b < elem_bytes) begin
            byte_idx = KEEP_IDX_W'((32'(slot_q) * NUM_ELEMENTS + i) * elem_bytes + b);
            merged_data[byte_idx] = in.data[i][b*8 +: 8];
            merged_keep[byte_idx] = in.keep[i];
          end
        end
      end
    end
  end

  always_comb begin
    slot_d      = slot_q;
    asm_data_d  = merged_data;
    asm_keep_d  = merged_keep;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    err_d       = err_q | (beat_acc & unsupported);
    if (close) begin
      // A close can only happen when the output register is free or draining this cycle.
      out_data_d  = merged_data;
      out_keep_d  = merged_keep;
      out_last_d  = in.last;
      out_valid_d = 1'b1;
      slot_d      = '0;
      asm_keep_d  = '0;
    end else begin
      if (beat_acc) begin
        slot_d = slot_q + SLOT_W'(1);
      end
      if (out.tready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q      <= '0;
      asm_keep_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      asm_keep_q  <= asm_keep_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_data_q <= asm_data_d;
    out_data_q <= out_data_d;
  end

  assign in.ready          = in_ready;
  assign actual_type.ready = beat_acc && in.last;
  assign out.tvalid        = out_valid_q;
  assign out.tdata         = out_data_q;
  assign out.tkeep         = out_keep_q;
  assign out.tlast         = out_last_q;
  assign err               = err_q;

`ifdef NDATA_PACK_BEAT_COUNT_EN
  logic [31:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (out_valid_q && out.tready) begin
      beat_count_d = beat_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
  assign xfer_done  = out_valid_q && out.tready && out_last_q;
`endif

endmodule
